n_term_ram_io_pipe: RTL
=======================

Name: n_term_ram_io_pipe

Overview:
Parametrised north terminal tile for the RAM_IO column, the successor to the purely combinational north terminator. It loops the N-bound wire bundle back onto the S-bound wires in one of four config-selected modes: combinational, pipelined, hold or zero. It adds an idle/stuck-wire activity monitor on the returning bundle. UserCLK and FrameStrobe pass through to the next tile unchanged.

Parameters:
W1, 4, wire count of N1END/S1BEG
W2, 8, wire count of N2MID/N2END/S2BEG/S2BEGb
W4, 16, wire count of N4END/S4BEG
LOOP_STAGES, 2, register stages in pipelined mode; legal 1..4
IDLE_W, 8, width of the idle counter
MaxFramesPerCol, 20, frame strobe width
FrameBitsPerRow, 32, frame data width (unused here, kept for tile uniformity)
NoConfigBits, 2, config bits consumed (mode select)

Ports:
UserCLK  input  1  tile clock
Reset  input  1  synchronous, active-high reset
N1END  input  W1  single-hop wires from south
N2MID  input  W2  double-hop mid wires
N2END  input  W2  double-hop end wires
N4END  input  W4  quad wires
S1BEG  output  W1  looped single-hop
S2BEG  output  W2  looped from N2MID
S2BEGb  output  W2  looped from N2END
S4BEG  output  W4  looped quad
ConfigBits  input  NoConfigBits  mode select from config latches
IdleCount  output  IDLE_W  cycles since last input change
IdleFlag  output  1  IdleCount saturated
UserCLKo  output  1  = UserCLK (pass-through)
FrameStrobe  input  MaxFramesPerCol  config strobes
FrameStrobe_O  output  MaxFramesPerCol  = FrameStrobe (pass-through)

Behaviour:
- Clock is UserCLK; reset is Reset, synchronous and active-high. No other clock or reset.
- Bundle B = {N4END, N2END, N2MID, N1END}, width W = W1+2*W2+W4 (36 at default). Outputs split identically: S1BEG<-N1END, S2BEG<-N2MID, S2BEGb<-N2END, S4BEG<-N4END slice.
- Pipeline P[0..LOOP_STAGES-1], each W bits. P[0]<=B, P[k]<=P[k-1]. Shifts every cycle except in mode HOLD. Reset clears all stages to 0.
- Mode = ConfigBits[1:0]:
  - 00 COMB: out = B (zero latency, bit-identical to the legacy terminator).
  - 01 PIPE: out = P[LOOP_STAGES-1]; latency exactly LOOP_STAGES cycles.
  - 10 HOLD: pipeline frozen; out = P[LOOP_STAGES-1].
  - 11 ZERO: out = 0; pipeline keeps shifting.
- Mode change is effective combinationally in the same cycle. HOLD->PIPE resumes shifting from the frozen contents with no flush. COMB/ZERO->PIPE outputs pipeline contents already loaded from B.
- During reset, outputs are 0 in PIPE/HOLD/ZERO and follow B in COMB. IdleCount=0, IdleFlag=0.
- Activity monitor: sample register Q<=B every cycle (reset 0).
  - If B==Q: IdleCount increments, saturating at 2^IDLE_W-1. Otherwise IdleCount<=0.
  - IdleFlag = (IdleCount == all-ones), combinational from the register.
  - The monitor runs in every mode and ignores HOLD.
- The first cycle after reset compares against Q=0. An all-zero input therefore counts as idle immediately.
- UserCLKo and FrameStrobe_O are pure wires with no registers.
- LOOP_STAGES outside 1..4 is illegal: elaboration must fail via a generate-time check.

Optional Feature:
N_TERM_LOOP_BIST_EN.
- Defined:
  - Adds input BistEn (1 bit) and output BistSignature (16 bits).
  - 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, steps every cycle while BistEn=1.
  - While BistEn=1, outputs = LFSR replicated and truncated to W bits, overriding every mode.
  - A 16-bit MISR with the same polynomial folds the XOR of B's 16-bit chunks (MSB chunk zero-padded) each BistEn cycle. Reset value 0; held while BistEn=0.
  - BistSignature = MISR.
- Undefined: neither port exists; behaviour is exactly as above.

Test Plan:
- Mode 00, drive N1END=4'hA, N2MID=8'h5C, N2END=8'h3F, N4END=16'h1234 -> S outputs equal the inputs in the same cycle.
- Mode 01, LOOP_STAGES=2, Reset for 2 cycles, then B=1,2,3 in consecutive cycles -> out 0,0,1,2,3; out is 0 during reset.
- Mode 01 streaming, switch to 10 for 5 cycles, then back to 01 -> out frozen at the last value, then resumes with the held stage contents and no gap or duplicate.
- Mode 11 with random B -> all S outputs 0. Switch to 01 -> first output is the B sampled LOOP_STAGES cycles earlier.
- IDLE_W=4: after reset, hold B=0 for 20 cycles -> IdleCount reaches 15 at cycle 15 and stays; IdleFlag=1. Toggle one N4END bit -> IdleCount=0 next cycle, IdleFlag=0.
- With N_TERM_LOOP_BIST_EN defined, BistEn=1 for 1 cycle after reset -> outputs show 16'hACE1 replicated. Hold N inputs at 0 for 100 cycles -> BistSignature stays 0. Compare against the golden model for a known input sequence.

Source files
------------

// File: rtl/n_term_ram_io_pipe.sv
// North terminal tile for the RAM_IO column.
// Loops the N-bound wire bundle back onto the S-bound wires in one of four
// config-selected modes (COMB, PIPE, HOLD, ZERO), with an idle/stuck-wire
// activity monitor on the returning bundle. UserCLK and FrameStrobe pass
// straight through to the next tile.
// Optional feature: define N_TERM_LOOP_BIST_EN to add an LFSR pattern
// generator (BistEn) and a MISR signature (BistSignature).
module n_term_ram_io_pipe #(
    parameter int W1              = 4,
    parameter int W2              = 8,
    parameter int W4              = 16,
    parameter int LOOP_STAGES     = 2,
    parameter int IDLE_W          = 8,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 2
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic [W1-1:0]              N1END,
    input  logic [W2-1:0]              N2MID,
    input  logic [W2-1:0]              N2END,
    input  logic [W4-1:0]              N4END,
    output logic [W1-1:0]              S1BEG,
    output logic [W2-1:0]              S2BEG,
    output logic [W2-1:0]              S2BEGb,
    output logic [W4-1:0]              S4BEG,
    input  logic [NoConfigBits-1:0]    ConfigBits,
    output logic [IDLE_W-1:0]          IdleCount,
    output logic                       IdleFlag,
`ifdef N_TERM_LOOP_BIST_EN
    input  logic                       BistEn,
    output logic [15:0]                BistSignature,
`endif
    output logic                       UserCLKo,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O
);

    localparam int W = W1 + 2*W2 + W4;

    typedef enum logic [1:0] {
        MODE_COMB = 2'b00,
        MODE_PIPE = 2'b01,
        MODE_HOLD = 2'b10,
        MODE_ZERO = 2'b11
    } mode_t;

    localparam logic [IDLE_W-1:0] IDLE_MAX = '1;

    // Elaboration-time legality checks
    if (LOOP_STAGES < 1 || LOOP_STAGES > 4) begin : g_bad_loop_stages
        $error("n_term_ram_io_pipe: LOOP_STAGES must be in 1..4");
    end
    if (FrameBitsPerRow < 1 || NoConfigBits < 2) begin : g_bad_config
        $error("n_term_ram_io_pipe: NoConfigBits must be >= 2 and FrameBitsPerRow >= 1");
    end

    mode_t            mode;
    logic [W-1:0]     bundle;
    logic [W-1:0]     pipe_q [LOOP_STAGES];
    logic [W-1:0]     pipe_tail;
    logic [W-1:0]     loop_out;
    logic             shift_en;
    logic [W-1:0]     sample_q;
    logic [IDLE_W-1:0] idle_q;

    assign mode      = mode_t'(ConfigBits[1:0]);
    assign bundle    = {N4END, N2END, N2MID, N1END};
    assign shift_en  = (mode != MODE_HOLD);
    assign pipe_tail = pipe_q[LOOP_STAGES-1];

    // Loop-back delay line: stage 0 captures the bundle, later stages shift
    for (genvar k = 0; k < LOOP_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // First stage loads the incoming bundle unless frozen
            always_ff @(posedge UserCLK) begin
                if (Reset) begin
                    pipe_q[0] <= '0;
                end else if (shift_en) begin
                    pipe_q[0] <= bundle;
                end
            end
        end else begin : g_body
            // Later stages take the previous stage unless frozen
            always_ff @(posedge UserCLK) begin
                if (Reset) begin
                    pipe_q[k] <= '0;
                end else if (shift_en) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end
    end

    // Activity monitor: count cycles the bundle has not changed, saturating
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            sample_q <= '0;
            idle_q   <= '0;
        end else begin
            sample_q <= bundle;
            if (bundle == sample_q) begin
                if (idle_q != IDLE_MAX) begin
                    idle_q <= idle_q + 1'b1;
                end
            end else begin
                idle_q <= '0;
            end
        end
    end

`ifdef N_TERM_LOOP_BIST_EN
    localparam int REPS = (W + 15) / 16;

    logic [15:0]        lfsr_q;
    logic [15:0]        misr_q;
    logic [15:0]        lfsr_fb;
    logic [15:0]        misr_fb;
    logic [15:0]        fold;
    logic [REPS*16-1:0] bundle_pad;
    logic [REPS*16-1:0] lfsr_rep;

    assign lfsr_fb  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign misr_fb  = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]};
    assign lfsr_rep = {REPS{lfsr_q}};

    // XOR-fold the bundle into one 16-bit word, top chunk zero-padded
    always_comb begin
        bundle_pad        = '0;
        bundle_pad[W-1:0] = bundle;
        fold              = '0;
        for (int unsigned c = 0; c < unsigned'(REPS); c++) begin
            fold = fold ^ bundle_pad[c*16 +: 16];
        end
    end

    // Pattern generator and signature register advance only while BIST runs
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            lfsr_q <= 16'hACE1;
            misr_q <= '0;
        end else if (BistEn) begin
            lfsr_q <= lfsr_fb;
            misr_q <= misr_fb ^ fold;
        end
    end

    assign BistSignature = misr_q;
`endif

    // Output select; registered paths read zero while reset is asserted
    always_comb begin
        loop_out = '0;
        case (mode)
            MODE_COMB: loop_out = bundle;
            MODE_PIPE,
            MODE_HOLD: loop_out = Reset ? '0 : pipe_tail;
            MODE_ZERO: loop_out = '0;
            default:   loop_out = '0;
        endcase
`ifdef N_TERM_LOOP_BIST_EN
        if (BistEn) begin
            loop_out = lfsr_rep[W-1:0];
        end
`endif
    end

    assign S1BEG  = loop_out[W1-1:0];
    assign S2BEG  = loop_out[W1 +: W2];
    assign S2BEGb = loop_out[W1+W2 +: W2];
    assign S4BEG  = loop_out[W1+2*W2 +: W4];

    assign IdleCount = Reset ? '0 : idle_q;
    assign IdleFlag  = !Reset && (idle_q == IDLE_MAX);

    assign UserCLKo      = UserCLK;
    assign FrameStrobe_O = FrameStrobe;

endmodule
